// File: rtl/io_xbar_credit_tracker.sv
// Multi-channel valid/yummy credit tracker for io_xbar output ports.
// Each channel counts free receiver NIB slots and flags protocol errors.
module io_xbar_credit_tracker #(
  parameter int NUM_CHANNELS = 4,
  parameter int BUFFER_SIZE  = 4,
  parameter int BUFFER_BITS  = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           valid,
  input  logic [NUM_CHANNELS-1:0]           yummy,
  input  logic                              err_clear,
  output logic [NUM_CHANNELS-1:0]           spc_avail,
  output logic [NUM_CHANNELS*BUFFER_BITS-1:0] credit_count,
  output logic                              all_idle,
  output logic [NUM_CHANNELS-1:0]           err_underflow,
  output logic [NUM_CHANNELS-1:0]           err_overflow
);

  localparam logic [BUFFER_BITS-1:0] FULL = BUFFER_BITS'(BUFFER_SIZE);

  logic [NUM_CHANNELS-1:0] idle;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic                   valid_f, yummy_f, is_one_f, is_two_or_more_f;
    logic                   underflow_f, overflow_f;
    logic [BUFFER_BITS-1:0] count_f, count_next;
    logic                   up, down, underflow, overflow;

    always_comb begin
      up         = yummy_f & ~valid_f;
      down       = valid_f & ~yummy_f;
      underflow  = down && (count_f == '0);
      overflow   = up && (count_f == FULL);
      count_next = count_f;
      if (up && !overflow)
        count_next = count_f + 1'b1;
      else if (down && !underflow)
        count_next = count_f - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_f          <= 1'b0;
        yummy_f          <= 1'b0;
        count_f          <= FULL;
        is_one_f         <= (BUFFER_SIZE == 1);
        is_two_or_more_f <= (BUFFER_SIZE >= 2);
        underflow_f      <= 1'b0;
        overflow_f       <= 1'b0;
      end else begin
        valid_f          <= valid[i];
        yummy_f          <= yummy[i];
        count_f          <= count_next;
        // Pre-decoded from the next count so spc_avail has no adder in its path.
        is_one_f         <= (count_next == BUFFER_BITS'(1));
        is_two_or_more_f <= (count_next >= BUFFER_BITS'(2));
        // A fresh error beats a simultaneous clear.
        underflow_f      <= (underflow_f & ~err_clear) | underflow;
        overflow_f       <= (overflow_f & ~err_clear) | overflow;
      end
    end

    assign spc_avail[i] = is_two_or_more_f | yummy_f | (is_one_f & ~valid_f);
    assign credit_count[i*BUFFER_BITS +: BUFFER_BITS] = count_f;
    assign err_underflow[i] = underflow_f;
    assign err_overflow[i]  = overflow_f;
    assign idle[i] = (count_f == FULL) & ~valid_f & ~yummy_f;
  end

  assign all_idle = &idle;

endmodule

// File: tb/tb_io_xbar_credit_tracker.sv
// Bench for io_xbar_credit_tracker: directed scenarios plus random traffic
// compared each cycle against an integer credit model.
module tb_io_xbar_credit_tracker;
  localparam int NC = 4;
  localparam int BS = 4;
  localparam int BB = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   valid, yummy;
  logic            err_clear;
  logic [NC-1:0]   spc_avail;
  logic [NC*BB-1:0] credit_count;
  logic            all_idle;
  logic [NC-1:0]   err_underflow, err_overflow;

  int checks = 0;
  int errors = 0;

  // Reference: credit count plus the flits/yummies still in flight one cycle.
  int mc[NC];
  bit mv[NC], my[NC], meu[NC], meo[NC];

  io_xbar_credit_tracker #(.NUM_CHANNELS(NC), .BUFFER_SIZE(BS), .BUFFER_BITS(BB)) dut (
    .clk(clk), .reset(reset), .valid(valid), .yummy(yummy), .err_clear(err_clear),
    .spc_avail(spc_avail), .credit_count(credit_count), .all_idle(all_idle),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, ch, obs, exp);
    end
  endtask

  task automatic model_update(input logic [NC-1:0] v, input logic [NC-1:0] y,
                              input logic c, input logic r);
    for (int i = 0; i < NC; i++) begin
      bit nu, no;
      nu = 0; no = 0;
      if (r) begin
        mc[i] = BS; mv[i] = 0; my[i] = 0; meu[i] = 0; meo[i] = 0;
      end else begin
        if (my[i] && !mv[i]) begin
          if (mc[i] == BS) no = 1; else mc[i] = mc[i] + 1;
        end else if (mv[i] && !my[i]) begin
          if (mc[i] == 0) nu = 1; else mc[i] = mc[i] - 1;
        end
        meu[i] = (meu[i] && !c) || nu;
        meo[i] = (meo[i] && !c) || no;
        mv[i] = v[i];
        my[i] = y[i];
      end
    end
  endtask

  task automatic check_all();
    bit idle_exp;
    idle_exp = 1;
    for (int i = 0; i < NC; i++) begin
      bit spc_exp;
      spc_exp = (mc[i] >= 2) || my[i] || (mc[i] == 1 && !mv[i]);
      chk("spc_avail", i, 32'(spc_avail[i]), 32'(spc_exp));
      chk("credit_count", i, 32'(credit_count[i*BB +: BB]), 32'(mc[i]));
      chk("err_underflow", i, 32'(err_underflow[i]), 32'(meu[i]));
      chk("err_overflow", i, 32'(err_overflow[i]), 32'(meo[i]));
      if (!(mc[i] == BS && !mv[i] && !my[i])) idle_exp = 0;
    end
    chk("all_idle", 0, 32'(all_idle), 32'(idle_exp));
  endtask

  task automatic cycle(input logic [NC-1:0] v, input logic [NC-1:0] y,
                       input logic c, input logic r);
    valid = v; yummy = y; err_clear = c; reset = r;
    @(posedge clk);
    model_update(v, y, c, r);
    #1;
    check_all();
  endtask

  task automatic reset_state_check(input string tag);
    chk({tag, "_spc"}, 0, 32'(spc_avail), 32'hF);
    chk({tag, "_cnt"}, 0, 32'(credit_count), 32'h924);
    chk({tag, "_idle"}, 0, 32'(all_idle), 32'h1);
    chk({tag, "_err"}, 0, 32'({err_underflow, err_overflow}), 32'h0);
  endtask

  initial begin
    valid = '0; yummy = '0; err_clear = 1'b0; reset = 1'b1;
    for (int i = 0; i < NC; i++) begin
      mc[i] = BS; mv[i] = 0; my[i] = 0; meu[i] = 0; meo[i] = 0;
    end

    // Reset state
    cycle(4'h0, 4'h0, 1'b0, 1'b1);
    cycle(4'h0, 4'h0, 1'b0, 1'b1);
    reset_state_check("reset");
    cycle(4'h0, 4'h0, 1'b0, 1'b0);

    // ch0 drains with four flits
    for (int k = 0; k < 4; k++) cycle(4'h1, 4'h0, 1'b0, 1'b0);
    chk("drain_spc_cyc4", 0, 32'(spc_avail[0]), 32'h0);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    chk("drain_cnt0", 0, 32'(credit_count[2:0]), 32'h0);
    chk("drain_others", 0, 32'(credit_count[11:3]), 32'h124);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);

    // yummy at zero credit: space returns one cycle after, count two after
    cycle(4'h0, 4'h1, 1'b0, 1'b0);
    chk("yummy_spc_t1", 0, 32'(spc_avail[0]), 32'h1);
    chk("yummy_cnt_t1", 0, 32'(credit_count[2:0]), 32'h0);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    chk("yummy_cnt_t2", 0, 32'(credit_count[2:0]), 32'h1);

    // ch1 to count 2, then simultaneous valid+yummy holds
    cycle(4'h2, 4'h0, 1'b0, 1'b0);
    cycle(4'h2, 4'h0, 1'b0, 1'b0);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cycle(4'h2, 4'h2, 1'b0, 1'b0);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    chk("hold_cnt1", 1, 32'(credit_count[5:3]), 32'h2);

    // ch2 overflow at full credit
    cycle(4'h0, 4'h4, 1'b0, 1'b0);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    chk("overflow_flag", 2, 32'(err_overflow[2]), 32'h1);
    chk("overflow_cnt", 2, 32'(credit_count[8:6]), 32'h4);

    // ch3 underflow after draining
    for (int k = 0; k < 5; k++) cycle(4'h8, 4'h0, 1'b0, 1'b0);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    chk("underflow_flag", 3, 32'(err_underflow[3]), 32'h1);
    chk("underflow_cnt", 3, 32'(credit_count[11:9]), 32'h0);

    // clear, then clear coinciding with a new underflow
    cycle(4'h0, 4'h0, 1'b1, 1'b0);
    chk("clear_flags", 0, 32'({err_underflow, err_overflow}), 32'h0);
    cycle(4'h8, 4'h0, 1'b0, 1'b0);
    cycle(4'h0, 4'h0, 1'b1, 1'b0);
    chk("clear_vs_new", 3, 32'(err_underflow[3]), 32'h1);

    // reset with traffic pending on every channel
    cycle(4'hF, 4'h5, 1'b0, 1'b0);
    cycle(4'h0, 4'h0, 1'b0, 1'b1);
    reset_state_check("midreset");
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    reset_state_check("postreset");

    // random traffic
    for (int k = 0; k < 400; k++) begin
      logic [NC-1:0] rv, ry;
      rv = NC'($urandom);
      ry = NC'($urandom);
      cycle(rv, ry, ($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
